// File: rtl/score_counter.sv
// score_counter: BCD score keeper driven by collision codes.
// A captured pill or power pellet adds its points one per clock, then the
// FSM waits for the collision code to change before accepting a new one.
module score_counter #(
  parameter int          NUM_DIGITS   = 3,
  parameter logic [3:0]  PILL_CODE    = 4'b0010,
  parameter logic [3:0]  POWER_CODE   = 4'b0110,
  parameter int          PILL_POINTS  = 1,
  parameter int          POWER_POINTS = 5,
  parameter int          TOTAL_PILLS  = 200
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [3:0]                collision_type,
  input  logic                      clear_level,
  output logic [4*NUM_DIGITS-1:0]   score_bcd,
  output logic [7*NUM_DIGITS-1:0]   hex,
  output logic [7:0]                pills_left,
  output logic                      all_eaten,
  output logic                      saturated
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    r_state;
  logic [3:0]                r_remaining;
  logic [3:0]                r_code;
  logic [4*NUM_DIGITS-1:0]   r_score;
  logic [7:0]                r_pills;
  logic                      r_saturated;

  logic [4*NUM_DIGITS-1:0]   w_score_inc;
  logic [NUM_DIGITS-1:0]     w_nine;
  logic                      w_all_nines;

  // Per-digit "is nine" flags; the score is at maximum when all are set.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nine
      assign w_nine[gi] = (r_score[4*gi +: 4] == 4'd9);
    end
  endgenerate

  assign w_all_nines = &w_nine;

  // Ripple BCD increment: nines wrap to zero and pass the carry upward.
  always_comb begin
    logic carry;
    w_score_inc = r_score;
    carry       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
  end

  // Control FSM with score, pill counter and sticky saturation flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= 4'd0;
      r_code      <= 4'd0;
      r_score     <= '0;
      r_pills     <= 8'(TOTAL_PILLS);
      r_saturated <= 1'b0;
    end else if (clear_level) begin
      // Level restart drops any in-flight points but keeps the score.
      r_state     <= IDLE;
      r_remaining <= 4'd0;
      r_pills     <= 8'(TOTAL_PILLS);
    end else begin
      case (r_state)
        IDLE: begin
          if (collision_type == PILL_CODE || collision_type == POWER_CODE) begin
            r_remaining <= (collision_type == PILL_CODE) ? 4'(PILL_POINTS)
                                                         : 4'(POWER_POINTS);
            r_code      <= collision_type;
            r_state     <= ADD;
            if (r_pills != 8'd0) begin
              r_pills <= r_pills - 8'd1;
            end
          end
        end
        ADD: begin
          if (w_all_nines) begin
            r_saturated <= 1'b1;
          end else begin
            r_score <= w_score_inc;
          end
          r_remaining <= r_remaining - 4'd1;
          if (r_remaining == 4'd1) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Wait for contact to end so a held code scores only once.
          if (collision_type != r_code) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Seven-segment decode (active low, gfedcba) for every digit.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hex
      always_comb begin
        case (r_score[4*gi +: 4])
          4'd0:    hex[7*gi +: 7] = 7'b1000000;
          4'd1:    hex[7*gi +: 7] = 7'b1111001;
          4'd2:    hex[7*gi +: 7] = 7'b0100100;
          4'd3:    hex[7*gi +: 7] = 7'b0110000;
          4'd4:    hex[7*gi +: 7] = 7'b0011001;
          4'd5:    hex[7*gi +: 7] = 7'b0010010;
          4'd6:    hex[7*gi +: 7] = 7'b0000010;
          4'd7:    hex[7*gi +: 7] = 7'b1111000;
          4'd8:    hex[7*gi +: 7] = 7'b0000000;
          4'd9:    hex[7*gi +: 7] = 7'b0010000;
          default: hex[7*gi +: 7] = 7'b1111111;
        endcase
      end
    end
  endgenerate

  assign score_bcd  = r_score;
  assign pills_left = r_pills;
  assign all_eaten  = (r_pills == 8'd0);
  assign saturated  = r_saturated;

endmodule
